// File: rtl/trace_pkg.sv
// Shared types and width helpers for the commit-trace capture buffer.
package trace_pkg;

    // Widest PC/data and instruction words an entry can hold. Narrower
    // XLEN/ILEN values are zero-extended into these fields and the unused
    // upper bits are optimised away by synthesis.
    localparam int TRACE_XLEN_MAX = 64;
    localparam int TRACE_ILEN_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_t;

    typedef struct packed {
        logic [TRACE_XLEN_MAX-1:0] pc;
        logic [TRACE_ILEN_MAX-1:0] instr;
        logic [4:0]                rd;
        logic                      we;
        logic [TRACE_XLEN_MAX-1:0] wdata;
    } trace_entry_t;

    // Address width for a DEPTH-entry buffer (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width: must be able to hold the value DEPTH itself.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
// The array is deliberately left without reset.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write one entry per enabled cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Readout must be zero-latency, so the read side is combinational.
    assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-trace capture buffer: records retired instructions into a circular
// buffer, freezes a configurable number of entries after a trigger, then
// drains the frozen window oldest-first over a valid/ready port.
// XLEN must not exceed 64 and ILEN must not exceed 32.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int ILEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cap_valid,
    input  logic [XLEN-1:0]      cap_pc,
    input  logic [ILEN-1:0]      cap_instr,
    input  logic [4:0]           cap_rd,
    input  logic                 cap_we,
    input  logic [XLEN-1:0]      cap_wdata,
    input  logic                 arm,
    input  logic                 trig_en,
    input  logic [XLEN-1:0]      trig_pc,
    input  logic                 trig_force,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [XLEN-1:0]      rd_pc,
    output logic [ILEN-1:0]      rd_instr,
    output logic [4:0]           rd_rd,
    output logic                 rd_we,
    output logic [XLEN-1:0]      rd_wdata,
    output logic                 rd_last,
    output logic [1:0]           state,
    output logic [$clog2(DEPTH):0] count,
    output logic [31:0]          commit_count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam int EW = $bits(trace_entry_t);

    trace_state_t  state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] post_q, post_d;
    logic [31:0]   commit_q, commit_d;

    logic          ram_we;
    logic          trig_hit;
    logic [CW-1:0] count_inc;
    logic [PW-1:0] rd_idx;
    trace_entry_t  wr_entry;
    trace_entry_t  rd_entry;
    logic [EW-1:0] rd_raw;

    // Registered state; reset returns everything except the array to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            post_q   <= '0;
            commit_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            post_q   <= post_d;
            commit_q <= commit_d;
        end
    end

    assign trig_hit  = cap_valid && (trig_force || (trig_en && (cap_pc == trig_pc)));
    // Occupancy saturates at DEPTH; beyond that the oldest entry is overwritten.
    assign count_inc = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);

    // Next-state logic: capture while ARMED/POST, drain or re-arm while DONE.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        post_d   = post_q;
        commit_d = commit_q;
        ram_we   = 1'b0;

        if (cap_valid) begin
            commit_d = commit_q + 32'd1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // arm wins over any same-cycle capture or readout handshake.
                if (arm) begin
                    state_d  = ST_ARMED;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    post_d   = '0;
                end else if ((state_q == ST_DONE) && rd_valid && rd_ready) begin
                    count_d = count_q - CW'(1);
                end
            end
            ST_ARMED: begin
                if (cap_valid) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    count_d  = count_inc;
                    if (trig_hit) begin
                        if (POST_TRIG == 0) begin
                            state_d = ST_DONE;
                        end else begin
                            post_d  = CW'(POST_TRIG);
                            state_d = ST_POST;
                        end
                    end
                end
            end
            ST_POST: begin
                // Triggers are ignored here; only the post counter matters.
                if (cap_valid) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    count_d  = count_inc;
                    post_d   = post_q - CW'(1);
                    if (post_q == CW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Build the stored entry; writes to x0 are recorded as no write-back.
    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = TRACE_XLEN_MAX'(cap_pc);
        wr_entry.instr = TRACE_ILEN_MAX'(cap_instr);
        wr_entry.rd    = cap_rd;
        wr_entry.we    = cap_we && (cap_rd != 5'd0);
        wr_entry.wdata = TRACE_XLEN_MAX'(cap_wdata);
    end

    // Oldest entry sits count positions behind the write pointer (mod DEPTH).
    assign rd_idx = wr_ptr_q - count_q[PW-1:0];

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_idx),
        .rdata (rd_raw)
    );

    assign rd_entry = trace_entry_t'(rd_raw);

    assign rd_valid     = (state_q == ST_DONE) && (count_q != '0);
    assign rd_last      = rd_valid && (count_q == CW'(1));
    assign rd_pc        = rd_valid ? rd_entry.pc[XLEN-1:0]    : '0;
    assign rd_instr     = rd_valid ? rd_entry.instr[ILEN-1:0] : '0;
    assign rd_rd        = rd_valid ? rd_entry.rd              : '0;
    assign rd_we        = rd_valid && rd_entry.we;
    assign rd_wdata     = rd_valid ? rd_entry.wdata[XLEN-1:0] : '0;
    assign state        = state_q;
    assign count        = count_q;
    assign commit_count = commit_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: two instances (POST_TRIG=2 and
// POST_TRIG=0, DEPTH=8) share the stimulus; a queue model of the frozen window
// supplies expected readout entries.
module tb_commit_trace_buffer;
    import trace_pkg::*;

    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            cap_valid = 1'b0;
    logic [XLEN-1:0] cap_pc = '0;
    logic [ILEN-1:0] cap_instr = '0;
    logic [4:0]      cap_rd = '0;
    logic            cap_we = 1'b0;
    logic [XLEN-1:0] cap_wdata = '0;
    logic            arm = 1'b0;
    logic            trig_en = 1'b1;
    logic [XLEN-1:0] trig_pc = 64'd40;
    logic            trig_force = 1'b0;
    logic            rd_ready = 1'b0;

    logic            d2_rd_valid, d0_rd_valid, d2_rd_we, d0_rd_we, d2_rd_last, d0_rd_last;
    logic [XLEN-1:0] d2_rd_pc, d0_rd_pc, d2_rd_wdata, d0_rd_wdata;
    logic [ILEN-1:0] d2_rd_instr, d0_rd_instr;
    logic [4:0]      d2_rd_rd, d0_rd_rd;
    logic [1:0]      d2_state, d0_state;
    logic [3:0]      d2_count, d0_count;
    logic [31:0]     d2_commit, d0_commit;

    // sel = 1 observes the POST_TRIG=0 instance, 0 the POST_TRIG=2 instance.
    logic            sel = 1'b0;
    logic            obs_rd_valid, obs_rd_we, obs_rd_last;
    logic [XLEN-1:0] obs_rd_pc, obs_rd_wdata;
    logic [ILEN-1:0] obs_rd_instr;
    logic [4:0]      obs_rd_rd;
    logic [1:0]      obs_state;
    logic [3:0]      obs_count;
    logic [31:0]     obs_commit;

    always #5 clk = ~clk;

    commit_trace_buffer #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .POST_TRIG(2)) dut (
        .clk(clk), .reset(reset), .cap_valid(cap_valid), .cap_pc(cap_pc),
        .cap_instr(cap_instr), .cap_rd(cap_rd), .cap_we(cap_we), .cap_wdata(cap_wdata),
        .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc), .trig_force(trig_force),
        .rd_valid(d2_rd_valid), .rd_ready(rd_ready), .rd_pc(d2_rd_pc), .rd_instr(d2_rd_instr),
        .rd_rd(d2_rd_rd), .rd_we(d2_rd_we), .rd_wdata(d2_rd_wdata), .rd_last(d2_rd_last),
        .state(d2_state), .count(d2_count), .commit_count(d2_commit)
    );

    commit_trace_buffer #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .POST_TRIG(0)) dut0 (
        .clk(clk), .reset(reset), .cap_valid(cap_valid), .cap_pc(cap_pc),
        .cap_instr(cap_instr), .cap_rd(cap_rd), .cap_we(cap_we), .cap_wdata(cap_wdata),
        .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc), .trig_force(trig_force),
        .rd_valid(d0_rd_valid), .rd_ready(rd_ready), .rd_pc(d0_rd_pc), .rd_instr(d0_rd_instr),
        .rd_rd(d0_rd_rd), .rd_we(d0_rd_we), .rd_wdata(d0_rd_wdata), .rd_last(d0_rd_last),
        .state(d0_state), .count(d0_count), .commit_count(d0_commit)
    );

    always_comb begin
        obs_rd_valid = sel ? d0_rd_valid : d2_rd_valid;
        obs_rd_pc    = sel ? d0_rd_pc    : d2_rd_pc;
        obs_rd_instr = sel ? d0_rd_instr : d2_rd_instr;
        obs_rd_rd    = sel ? d0_rd_rd    : d2_rd_rd;
        obs_rd_we    = sel ? d0_rd_we    : d2_rd_we;
        obs_rd_wdata = sel ? d0_rd_wdata : d2_rd_wdata;
        obs_rd_last  = sel ? d0_rd_last  : d2_rd_last;
        obs_state    = sel ? d0_state    : d2_state;
        obs_count    = sel ? d0_count    : d2_count;
        obs_commit   = sel ? d0_commit   : d2_commit;
    end

    // Behavioural model: window of retained entries plus capture state.
    int           m_state;
    int           m_post;
    int           m_post_trig;
    logic [31:0]  m_commit;
    trace_entry_t exp_q[$];
    int           n_checks = 0;
    int           n_fail = 0;

    task automatic model_reset();
        m_state  = 0;
        m_post   = 0;
        m_commit = '0;
        exp_q.delete();
    endtask

    task automatic push_capture();
        trace_entry_t e;
        e       = '0;
        e.pc    = cap_pc;
        e.instr = cap_instr;
        e.rd    = cap_rd;
        e.we    = cap_we && (cap_rd != 5'd0);
        e.wdata = cap_wdata;
        exp_q.push_back(e);
        if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
    endtask

    task automatic model_step();
        if (cap_valid) m_commit = m_commit + 32'd1;
        case (m_state)
            0, 3: if (arm) begin exp_q.delete(); m_state = 1; end
            1: if (cap_valid) begin
                push_capture();
                if (trig_force || (trig_en && cap_pc == trig_pc)) begin
                    if (m_post_trig == 0) m_state = 3;
                    else begin m_post = m_post_trig; m_state = 2; end
                end
            end
            2: if (cap_valid) begin
                push_capture();
                m_post = m_post - 1;
                if (m_post == 0) m_state = 3;
            end
            default: ;
        endcase
    endtask

    // One clock: update model with the driven inputs, advance, clear pulses.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        cap_valid  = 1'b0;
        arm        = 1'b0;
        trig_force = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        cycle();
    endtask

    task automatic capture(input logic [XLEN-1:0] pc, input logic [4:0] rd, input logic force_trig);
        cap_valid  = 1'b1;
        cap_pc     = pc;
        cap_instr  = $urandom;
        cap_rd     = rd;
        cap_we     = 1'b1;
        cap_wdata  = {$urandom, $urandom};
        trig_force = force_trig;
        cycle();
    endtask

    // Drain the frozen window, comparing each presented entry with the model.
    task automatic drain(input string tag, input bit toggle, input int max_entries);
        int  budget = 0;
        int  taken = 0;
        bit  rdy = 1'b1;
        while (exp_q.size() != 0 && taken < max_entries && budget < 64) begin
            rd_ready = toggle ? rdy : 1'b1;
            n_checks++;
            if (obs_rd_valid !== 1'b1 || obs_rd_pc !== exp_q[0].pc || obs_rd_instr !== exp_q[0].instr
                || obs_rd_rd !== exp_q[0].rd || obs_rd_we !== exp_q[0].we || obs_rd_wdata !== exp_q[0].wdata
                || obs_rd_last !== 1'(exp_q.size() == 1) || obs_count !== 4'(exp_q.size())) begin
                n_fail++;
                $display("FAIL %s entry: got v=%0b pc=%0d rd=%0d we=%0b last=%0b cnt=%0d, want pc=%0d rd=%0d we=%0b last=%0b cnt=%0d",
                         tag, obs_rd_valid, obs_rd_pc, obs_rd_rd, obs_rd_we, obs_rd_last, obs_count,
                         exp_q[0].pc, exp_q[0].rd, exp_q[0].we, exp_q.size() == 1, exp_q.size());
            end else begin
                $display("%s: pc=%0d ready=%0b last=%0b", tag, obs_rd_pc, rd_ready, obs_rd_last);
            end
            if (rd_ready) begin
                void'(exp_q.pop_front());
                taken++;
            end
            @(posedge clk);
            #1;
            rdy = ~rdy;
            budget++;
        end
        rd_ready = 1'b0;
        n_checks++;
        if (budget >= 64) begin
            n_fail++;
            $display("FAIL %s drain timeout: %0d entries left", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs_state !== 2'd0 || obs_count !== 4'd0 || obs_commit !== 32'd0 || obs_rd_valid !== 1'b0
            || obs_rd_pc !== '0 || obs_rd_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: state=%0d count=%0d commit=%0d rd_valid=%0b rd_pc=%0d, want all 0",
                     obs_state, obs_count, obs_commit, obs_rd_valid, obs_rd_pc);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (obs_state !== 2'd0 || obs_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset idle: state=%0d count=%0d, want 0/0", obs_state, obs_count);
        end
        $display("test_reset done");
    endtask

    task automatic test_pc_trigger_wrap();
        sel = 1'b0; m_post_trig = 2; trig_en = 1'b1; trig_pc = 64'd40;
        apply_reset();
        do_arm();
        for (int i = 0; i < 20; i++) begin
            capture(64'(i * 4), 5'(i), 1'b0);
            n_checks++;
            if (obs_state !== 2'(m_state)) begin
                n_fail++;
                $display("FAIL wrap state after pc=%0d: got %0d want %0d", i * 4, obs_state, m_state);
            end
        end
        n_checks++;
        if (obs_count !== 4'd8 || obs_commit !== 32'd20 || obs_state !== 2'd3) begin
            n_fail++;
            $display("FAIL wrap totals: count=%0d commit=%0d state=%0d, want 8/20/3", obs_count, obs_commit, obs_state);
        end
        n_checks++;
        if (exp_q[0].pc !== 64'd20 || exp_q[exp_q.size()-1].pc !== 64'd48) begin
            n_fail++;
            $display("FAIL wrap window: model holds pc %0d..%0d, want 20..48", exp_q[0].pc, exp_q[exp_q.size()-1].pc);
        end
        drain("wrap", 1'b0, 99);
        n_checks++;
        if (obs_rd_valid !== 1'b0 || obs_state !== 2'd3 || obs_rd_pc !== '0) begin
            n_fail++;
            $display("FAIL wrap drained: rd_valid=%0b state=%0d rd_pc=%0d, want 0/3/0", obs_rd_valid, obs_state, obs_rd_pc);
        end
    endtask

    task automatic test_force_post0();
        sel = 1'b1; m_post_trig = 0; trig_en = 1'b1; trig_pc = 64'd40;
        apply_reset();
        do_arm();
        for (int i = 0; i < 3; i++) capture(64'(i * 4), 5'(i + 1), 1'(i == 2));
        n_checks++;
        if (obs_state !== 2'd3 || obs_count !== 4'd3) begin
            n_fail++;
            $display("FAIL post0: state=%0d count=%0d, want 3/3", obs_state, obs_count);
        end
        drain("post0", 1'b0, 99);
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        sel = 1'b0; m_post_trig = 2; trig_en = 1'b0;
        apply_reset();
        do_arm();
        for (int i = 0; i < 6; i++) capture(64'(300 + i * 4), 5'(i + 7), 1'(i == 1));
        n_checks++;
        if (obs_state !== 2'd3 || obs_count !== 4'd4 || obs_commit !== 32'd6) begin
            n_fail++;
            $display("FAIL backpressure totals: state=%0d count=%0d commit=%0d, want 3/4/6", obs_state, obs_count, obs_commit);
        end
        drain("bp", 1'b1, 99);
        trig_en = 1'b1;
    endtask

    task automatic test_x0_rearm();
        sel = 1'b0; m_post_trig = 2; trig_pc = 64'd40;
        apply_reset();
        do_arm();
        capture(64'd100, 5'd0, 1'b0);
        capture(64'd104, 5'd3, 1'b0);
        capture(64'd108, 5'd0, 1'b1);
        capture(64'd112, 5'd4, 1'b0);
        capture(64'd116, 5'd5, 1'b0);
        n_checks++;
        if (obs_rd_valid !== 1'b1 || obs_rd_pc !== 64'd100 || obs_rd_we !== 1'b0) begin
            n_fail++;
            $display("FAIL x0 entry: valid=%0b pc=%0d we=%0b, want 1/100/0", obs_rd_valid, obs_rd_pc, obs_rd_we);
        end
        drain("x0", 1'b0, 2);
        // Re-arm after partial drain, with a capture in the same cycle.
        arm = 1'b1; cap_valid = 1'b1; cap_pc = 64'd500; cap_rd = 5'd1;
        cycle();
        n_checks++;
        if (obs_state !== 2'd1 || obs_count !== 4'd0 || obs_rd_valid !== 1'b0 || obs_commit !== m_commit) begin
            n_fail++;
            $display("FAIL rearm: state=%0d count=%0d rd_valid=%0b commit=%0d, want 1/0/0/%0d",
                     obs_state, obs_count, obs_rd_valid, obs_commit, m_commit);
        end
    endtask

    task automatic test_reset_mid_post();
        sel = 1'b0; m_post_trig = 2; trig_pc = 64'd40;
        apply_reset();
        do_arm();
        capture(64'd200, 5'd2, 1'b1);
        capture(64'd204, 5'd3, 1'b0);
        n_checks++;
        if (obs_state !== 2'd2 || obs_count !== 4'd2) begin
            n_fail++;
            $display("FAIL mid-post: state=%0d count=%0d, want 2/2", obs_state, obs_count);
        end
        reset = 1'b0;
        #2;
        n_checks++;
        if (obs_state !== 2'd0 || obs_count !== 4'd0 || obs_rd_valid !== 1'b0 || obs_commit !== 32'd0) begin
            n_fail++;
            $display("FAIL async reset: state=%0d count=%0d rd_valid=%0b commit=%0d, want all 0",
                     obs_state, obs_count, obs_rd_valid, obs_commit);
        end
        #2;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_arm();
        for (int i = 0; i < 3; i++) capture(64'(600 + i * 4), 5'(i + 9), 1'(i == 0));
        n_checks++;
        if (obs_state !== 2'd3 || obs_count !== 4'd3 || obs_commit !== 32'd3) begin
            n_fail++;
            $display("FAIL post-reset capture: state=%0d count=%0d commit=%0d, want 3/3/3", obs_state, obs_count, obs_commit);
        end
        drain("rst", 1'b0, 99);
    endtask

    initial begin
        m_post_trig = 2;
        model_reset();
        test_reset();
        test_pc_trigger_wrap();
        test_force_post0();
        test_backpressure();
        test_x0_rearm();
        test_reset_mid_post();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
